// File: rtl/sample_tick_gen.sv
// Fractional sample-rate clock enable: a phase accumulator whose carry-out becomes a
// one-cycle tick. The increment can be reloaded at runtime and only switches on a tick boundary.
module sample_tick_gen #(
  parameter int unsigned      ACC_W       = 32,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(64'd8246337),
  parameter int unsigned      HOLDOFF_CYC = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [ACC_W-1:0] cfg_inc_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic             tick_o,
  output logic [7:0]       phase_o,
  output logic [15:0]      tick_count_o,
  output logic             busy_o
);

  localparam int unsigned HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {S_HOLDOFF, S_IDLE, S_RUN} state_e;

  state_e             state_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   inc_active_q;
  logic [ACC_W-1:0]   inc_pending_q;
  logic               pending_q;
  logic               tick_q;
  logic [15:0]        tick_count_q;

  logic [ACC_W:0]     sum_d;
  logic               run;
  logic               carry;
  logic               xfer;
  logic               apply;

  assign run   = (state_q == S_RUN);
  assign sum_d = {1'b0, acc_q} + {1'b0, inc_active_q};
  assign carry = run && sum_d[ACC_W];

  assign cfg_ready_o = (state_q != S_HOLDOFF) && !pending_q;
  assign xfer        = cfg_valid_i && cfg_ready_o;
  // Swap only where it cannot stretch or shorten a sample period: on the carrying add
  // (which still uses the old increment), when not running, or when the accumulator is stalled.
  assign apply       = pending_q && (!run || carry || (inc_active_q == '0));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_HOLDOFF;
      hold_cnt_q    <= '0;
      acc_q         <= '0;
      inc_active_q  <= DEFAULT_INC;
      inc_pending_q <= '0;
      pending_q     <= 1'b0;
      tick_q        <= 1'b0;
      tick_count_q  <= '0;
    end else begin
      tick_q <= carry;
      if (carry) tick_count_q <= tick_count_q + 16'd1;
      if (run)   acc_q        <= sum_d[ACC_W-1:0];

      if (apply) begin
        inc_active_q <= inc_pending_q;
        pending_q    <= 1'b0;
      end else if (xfer) begin
        inc_pending_q <= cfg_inc_i;
        pending_q     <= 1'b1;
      end

      // Leaving RUN still performs that cycle's add, so a final carry keeps its tick.
      case (state_q)
        S_HOLDOFF: begin
          if (hold_cnt_q == HOLD_LAST) state_q <= S_IDLE;
          else                         hold_cnt_q <= hold_cnt_q + 1'b1;
        end
        S_IDLE:  if (en_i)  state_q <= S_RUN;
        S_RUN:   if (!en_i) state_q <= S_IDLE;
        default: state_q <= S_HOLDOFF;
      endcase
    end
  end

  assign tick_o       = tick_q;
  assign phase_o      = acc_q[ACC_W-1 -: 8];
  assign tick_count_o = tick_count_q;
  assign busy_o       = run;

endmodule

// File: tb/tb_sample_tick_gen.sv
// Directed bench for sample_tick_gen at ACC_W=8, DEFAULT_INC=64, HOLDOFF_CYC=4:
// a per-cycle vector table for startup and increment changes, then hand sequences.
module tb_sample_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  cfg_inc;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        tick;
  logic [7:0]  phase;
  logic [15:0] tick_count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sample_tick_gen #(.ACC_W(8), .DEFAULT_INC(8'd64), .HOLDOFF_CYC(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .cfg_inc_i(cfg_inc),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .tick_o(tick),
    .phase_o(phase), .tick_count_o(tick_count), .busy_o(busy)
  );

  typedef struct {
    logic        en;
    logic        vld;
    logic [7:0]  inc;
    logic        tick;
    logic [7:0]  ph;
    logic [15:0] cnt;
    logic        rdy;
    logic        busy;
  } vec_t;

  vec_t tbl [38];

  function automatic vec_t mk(logic e, logic v, logic [7:0] i, logic t, logic [7:0] p,
                              logic [15:0] c, logic r, logic b);
    vec_t x;
    x.en = e; x.vld = v; x.inc = i; x.tick = t; x.ph = p; x.cnt = c; x.rdy = r; x.busy = b;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int nt;
    logic [15:0] tc0;
    bit found;

    //             en vld inc    tick ph     cnt rdy busy
    tbl[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0,  0, 0);
    tbl[1]  = mk(1, 1, 8'h10, 0, 8'h00, 0,  0, 0);
    tbl[2]  = mk(1, 1, 8'h10, 0, 8'h00, 0,  0, 0);
    tbl[3]  = mk(1, 1, 8'h10, 0, 8'h00, 0,  0, 0);
    tbl[4]  = mk(1, 0, 8'h00, 0, 8'h00, 0,  1, 0);
    tbl[5]  = mk(1, 0, 8'h00, 0, 8'h00, 0,  1, 1);
    tbl[6]  = mk(1, 0, 8'h00, 0, 8'h40, 0,  1, 1);
    tbl[7]  = mk(1, 0, 8'h00, 0, 8'h80, 0,  1, 1);
    tbl[8]  = mk(1, 0, 8'h00, 0, 8'hC0, 0,  1, 1);
    tbl[9]  = mk(1, 0, 8'h00, 1, 8'h00, 1,  1, 1);
    tbl[10] = mk(1, 0, 8'h00, 0, 8'h40, 1,  1, 1);
    tbl[11] = mk(1, 0, 8'h00, 0, 8'h80, 1,  1, 1);
    tbl[12] = mk(1, 0, 8'h00, 0, 8'hC0, 1,  1, 1);
    tbl[13] = mk(1, 0, 8'h00, 1, 8'h00, 2,  1, 1);
    tbl[14] = mk(1, 0, 8'h00, 0, 8'h40, 2,  1, 1);
    tbl[15] = mk(1, 0, 8'h00, 0, 8'h80, 2,  1, 1);
    tbl[16] = mk(1, 0, 8'h00, 0, 8'hC0, 2,  1, 1);
    tbl[17] = mk(1, 0, 8'h00, 1, 8'h00, 3,  1, 1);
    tbl[18] = mk(1, 0, 8'h00, 0, 8'h40, 3,  1, 1);
    tbl[19] = mk(1, 1, 8'h80, 0, 8'h80, 3,  1, 1);
    tbl[20] = mk(1, 0, 8'h00, 0, 8'hC0, 3,  0, 1);
    tbl[21] = mk(1, 0, 8'h00, 1, 8'h00, 4,  1, 1);
    tbl[22] = mk(1, 0, 8'h00, 0, 8'h80, 4,  1, 1);
    tbl[23] = mk(1, 0, 8'h00, 1, 8'h00, 5,  1, 1);
    tbl[24] = mk(1, 0, 8'h00, 0, 8'h80, 5,  1, 1);
    tbl[25] = mk(1, 0, 8'h00, 1, 8'h00, 6,  1, 1);
    tbl[26] = mk(1, 1, 8'h00, 0, 8'h80, 6,  1, 1);
    tbl[27] = mk(1, 0, 8'h00, 1, 8'h00, 7,  0, 1);
    tbl[28] = mk(1, 0, 8'h00, 0, 8'h80, 7,  0, 1);
    tbl[29] = mk(1, 0, 8'h00, 1, 8'h00, 8,  1, 1);
    tbl[30] = mk(1, 0, 8'h00, 0, 8'h00, 8,  1, 1);
    tbl[31] = mk(1, 0, 8'h00, 0, 8'h00, 8,  1, 1);
    tbl[32] = mk(1, 1, 8'hFF, 0, 8'h00, 8,  1, 1);
    tbl[33] = mk(1, 0, 8'h00, 0, 8'h00, 8,  0, 1);
    tbl[34] = mk(1, 0, 8'h00, 0, 8'h00, 8,  1, 1);
    tbl[35] = mk(1, 0, 8'h00, 0, 8'hFF, 8,  1, 1);
    tbl[36] = mk(1, 0, 8'h00, 1, 8'hFE, 9,  1, 1);
    tbl[37] = mk(1, 0, 8'h00, 1, 8'hFD, 10, 1, 1);

    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_inc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 38; i++) begin
      en = tbl[i].en; cfg_valid = tbl[i].vld; cfg_inc = tbl[i].inc;
      chk($sformatf("tbl%0d_tick", i),  tick,       tbl[i].tick);
      chk($sformatf("tbl%0d_phase", i), phase,      tbl[i].ph);
      chk($sformatf("tbl%0d_cnt", i),   tick_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_ready", i), cfg_ready,  tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i),  busy,       tbl[i].busy);
      step();
    end
    cfg_valid = 1'b0;

    // inc=255: any 256 consecutive cycles hold exactly 255 ticks
    tc0 = tick_count; nt = 0;
    for (int i = 0; i < 256; i++) begin
      if (tick) nt++;
      step();
    end
    chk("max_rate_ticks", nt, 255);
    chk("max_rate_count", tick_count, tc0 + 16'd255);

    // tick_count wrap
    found = 0;
    for (int i = 0; i < 70000 && !found; i++) begin
      if (tick_count == 16'hFFFF) found = 1;
      else step();
    end
    chk("wrap_reached", found, 1);
    if (found) begin
      chk("wrap_ffff_on_tick", tick, 1);
      step();
      for (int j = 0; j < 4 && !tick; j++) step();
      chk("wrap_tick", tick, 1);
      chk("wrap_zero", tick_count, 16'h0000);
    end

    // slow increment so the next update stays pending, then reset on top of it
    chk("pre_inc1_ready", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_inc = 8'h01;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 8 && !cfg_ready; i++) step();
    chk("inc1_applied_ready", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_inc = 8'h80;
    step();
    cfg_valid = 1'b0;
    chk("pend_ready_low", cfg_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_phase", phase, 0);
    chk("arst_cnt", tick_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      chk($sformatf("rst2_c%0d_tick", c), tick, (c == 9 || c == 13));
      if (c == 4) chk("rst2_ready", cfg_ready, 1);
      if (c == 4) chk("rst2_busy_idle", busy, 0);
      if (c == 5) chk("rst2_busy_run", busy, 1);
      if (c == 6) chk("rst2_phase", phase, 8'h40);
      if (c == 13) chk("rst2_cnt", tick_count, 2);
      step();
    end

    // en held low with acc parked at 0x50, then resume
    rst_n = 1'b0; en = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    chk("c_ready4", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_inc = 8'h50;
    step();
    cfg_valid = 1'b0;
    chk("c_ready5", cfg_ready, 0);
    step();
    chk("c_ready6", cfg_ready, 1);
    en = 1'b1;
    step();
    chk("c_busy7", busy, 1);
    en = 1'b0;
    step();
    chk("c_busy8", busy, 0);
    chk("c_phase8", phase, 8'h50);
    cfg_valid = 1'b1; cfg_inc = 8'h40;
    step();
    cfg_valid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d_phase", i), phase, 8'h50);
      chk($sformatf("hold%0d_tick", i), tick, 0);
      step();
    end
    en = 1'b1;
    step();
    step();
    chk("res_phase1", phase, 8'h90);
    chk("res_tick1", tick, 0);
    step();
    chk("res_phase2", phase, 8'hD0);
    chk("res_tick2", tick, 0);
    step();
    chk("res_phase3", phase, 8'h10);
    chk("res_tick3", tick, 1);
    chk("res_cnt3", tick_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
